// File: rtl/l1_data_pkg.sv
// Shared definitions for the L1 data-cache hit-rate monitor: fill-state
// encoding, default window/hysteresis constants and a pointer-width helper.
package l1_data_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } fill_state_e;

  localparam int DEFAULT_WINDOW = 100;
  localparam int DEFAULT_HYST   = 4;

  // A ring of depth N needs ceil(log2(N)) pointer bits, but never fewer than one.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/l1_data_hit_ring.sv
// One-bit-wide sample ring with a wrapping write pointer. The bit about to be
// overwritten is presented on evict_bit so the caller can retire it.
module l1_data_hit_ring
  import l1_data_pkg::*;
#(
  parameter int P_WINDOW = DEFAULT_WINDOW
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic write_en,
  input  logic write_bit,
  output logic evict_bit
);

  localparam int PW = ptr_width(P_WINDOW);
  localparam logic [PW-1:0] LAST_SLOT = PW'(P_WINDOW - 1);

  logic [P_WINDOW-1:0] slots;
  logic [PW-1:0]       ptr;

  // NOTE: the storage is plain flops, so it is cleared on reset together with
  // the pointer; a RAM-based ring could not be, and would rely on the state mask.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      slots <= '0;
      ptr   <= '0;
    end else if (write_en) begin
      slots[ptr] <= write_bit;
      ptr        <= (ptr == LAST_SLOT) ? '0 : ptr + PW'(1);
    end
  end

  assign evict_bit = slots[ptr];

endmodule

// File: rtl/l1_data_cache_hit_monitor.sv
// Sliding-window cache hit counter with a low-hit-rate alarm and release
// hysteresis. All outputs are registered one cycle after the accepted sample.
module l1_data_cache_hit_monitor
  import l1_data_pkg::*;
#(
  parameter int P_WINDOW = DEFAULT_WINDOW,
  parameter int P_CW     = $clog2(P_WINDOW + 1),
  parameter int P_HYST   = DEFAULT_HYST
) (
  input  logic            iCLOCK,
  input  logic            iRESET_SYNC,
  input  logic            iCLEAR,
  input  logic            iCACHE_VALID,
  input  logic            iCACHE_HIT,
  input  logic [P_CW-1:0] iTHRESHOLD,
  output logic [P_CW-1:0] oINFO_COUNT,
  output logic [P_CW-1:0] oINFO_SAMPLES,
  output logic            oINFO_FULL,
  output logic            oINFO_LOW_HIT,
  output logic            oINFO_UPDATE
);

  localparam logic [P_CW-1:0] WINDOW_C = P_CW'(P_WINDOW);
  // Hysteresis larger than any threshold can be saturated without changing behaviour.
  localparam logic [P_CW:0]   HYST_SAT = (P_HYST >= (1 << P_CW)) ?
                                         {1'b0, {P_CW{1'b1}}} : (P_CW + 1)'(P_HYST);

  fill_state_e     state;
  fill_state_e     state_next;
  logic            accept;
  logic            evict_raw;
  logic            evict;
  logic [P_CW-1:0] count_next;
  logic [P_CW-1:0] samples_next;
  logic [P_CW:0]   release_level;
  logic            low_next;

  assign accept = iCACHE_VALID && !iCLEAR;

  l1_data_hit_ring #(
    .P_WINDOW (P_WINDOW)
  ) u_ring (
    .clk       (iCLOCK),
    .rst       (iRESET_SYNC),
    .clear     (iCLEAR),
    .write_en  (accept),
    .write_bit (iCACHE_HIT),
    .evict_bit (evict_raw)
  );

  // NOTE: every signal gets its default first so no path leaves it unassigned
  // (which would otherwise infer a latch).
  always_comb begin
    state_next    = state;
    count_next    = oINFO_COUNT;
    samples_next  = oINFO_SAMPLES;
    low_next      = oINFO_LOW_HIT;
    evict         = (state == ST_FULL) && evict_raw;
    release_level = {1'b0, iTHRESHOLD} + HYST_SAT;

    if (accept) begin
      // Stale ring contents only matter once the window has wrapped.
      count_next = oINFO_COUNT + P_CW'(iCACHE_HIT) - P_CW'(evict);
      if (state != ST_FULL) begin
        samples_next = oINFO_SAMPLES + P_CW'(1);
      end
      state_next = (samples_next == WINDOW_C) ? ST_FULL : ST_FILL;
    end

    // The threshold is live every cycle, so the alarm re-evaluates even when idle.
    if ((state_next == ST_FULL) && (count_next < iTHRESHOLD)) begin
      low_next = 1'b1;
    end else if ({1'b0, count_next} >= release_level) begin
      low_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iCLEAR) begin
      state         <= ST_EMPTY;
      oINFO_COUNT   <= '0;
      oINFO_SAMPLES <= '0;
      oINFO_FULL    <= 1'b0;
      oINFO_LOW_HIT <= 1'b0;
      oINFO_UPDATE  <= 1'b0;
    end else begin
      state         <= state_next;
      oINFO_COUNT   <= count_next;
      oINFO_SAMPLES <= samples_next;
      oINFO_FULL    <= (state_next == ST_FULL);
      oINFO_LOW_HIT <= low_next;
      oINFO_UPDATE  <= accept;
    end
  end

endmodule

// File: tb/tb_l1_data_cache_hit_monitor.sv
// Bench for the hit monitor: a hand-derived vector table, multi-cycle corner
// sequences, then random traffic against a queue-based window model.
module tb_l1_data_cache_hit_monitor;

  localparam int W    = 8;
  localparam int HYST = 2;
  localparam int CW   = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          valid;
  logic          hit;
  logic [CW-1:0] thr;
  logic [CW-1:0] count;
  logic [CW-1:0] samples;
  logic          full;
  logic          low_hit;
  logic          update;

  int tests = 0;
  int fails = 0;

  l1_data_cache_hit_monitor #(
    .P_WINDOW (W),
    .P_HYST   (HYST)
  ) dut (
    .iCLOCK        (clk),
    .iRESET_SYNC   (rst),
    .iCLEAR        (clr),
    .iCACHE_VALID  (valid),
    .iCACHE_HIT    (hit),
    .iTHRESHOLD    (thr),
    .oINFO_COUNT   (count),
    .oINFO_SAMPLES (samples),
    .oINFO_FULL    (full),
    .oINFO_LOW_HIT (low_hit),
    .oINFO_UPDATE  (update)
  );

  always #5 clk = ~clk;

  // Reference model: the window is literally the last W accepted hit flags.
  bit m_q[$];
  bit m_low;
  bit m_upd;

  function automatic int m_count();
    int s = 0;
    foreach (m_q[i]) s += int'(m_q[i]);
    return s;
  endfunction

  task automatic model_cycle(input logic r, input logic c, input logic v,
                             input logic h, input int t);
    int cnt;
    if (r || c) begin
      m_q.delete();
      m_low = 1'b0;
      m_upd = 1'b0;
      return;
    end
    m_upd = v;
    if (v) begin
      m_q.push_back(h);
      if (m_q.size() > W) void'(m_q.pop_front());
    end
    cnt = m_count();
    if (m_q.size() == W && cnt < t) m_low = 1'b1;
    else if (cnt >= t + HYST) m_low = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int c, input int s,
                            input logic f, input logic l, input logic u);
    check({tag, ".count"},   32'(count),   32'(c));
    check({tag, ".samples"}, 32'(samples), 32'(s));
    check({tag, ".full"},    32'(full),    32'(f));
    check({tag, ".low_hit"}, 32'(low_hit), 32'(l));
    check({tag, ".update"},  32'(update),  32'(u));
  endtask

  // Drive one cycle's inputs, advance past the edge, and update the model.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic h, input logic [CW-1:0] t);
    rst = r; clr = c; valid = v; hit = h; thr = t;
    @(posedge clk);
    model_cycle(r, c, v, h, int'(t));
    #1;
  endtask

  typedef struct {
    logic          clr;
    logic          valid;
    logic          hit;
    logic [CW-1:0] thr;
    int            count;
    int            samples;
    logic          full;
    logic          low;
    logic          upd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic c, input logic v, input logic h, input int t,
                              input int ec, input int es, input logic ef,
                              input logic el, input logic eu);
    vec_t e;
    e.clr = c; e.valid = v; e.hit = h; e.thr = CW'(t);
    e.count = ec; e.samples = es; e.full = ef; e.low = el; e.upd = eu;
    tbl.push_back(e);
  endfunction

  initial begin
    // Fill with 8 hits: count and samples climb together, full on the 8th.
    for (int i = 1; i <= W; i++) add(0, 1, 1, 4, i, i, (i == W), 0, 1);
    // Three misses evict hits: 7, 6, 5 with samples pinned at 8.
    add(0, 1, 0, 4, 7, 8, 1, 0, 1);
    add(0, 1, 0, 4, 6, 8, 1, 0, 1);
    add(0, 1, 0, 4, 5, 8, 1, 0, 1);
    // Hit flag without valid changes nothing and gives no pulse.
    add(0, 0, 1, 4, 5, 8, 1, 0, 0);
    // Fall to 4 (not below threshold), then to 3 -> alarm.
    add(0, 1, 0, 4, 4, 8, 1, 0, 1);
    add(0, 1, 0, 4, 3, 8, 1, 1, 1);
    // Hits overwriting hits keep the count at 3.
    add(0, 1, 1, 4, 3, 8, 1, 1, 1);
    add(0, 1, 1, 4, 3, 8, 1, 1, 1);
    add(0, 1, 1, 4, 3, 8, 1, 1, 1);
    // Wrapped pointer now overwrites misses: 4, 5 hold the alarm, 6 releases it.
    add(0, 1, 1, 4, 4, 8, 1, 1, 1);
    add(0, 1, 1, 4, 5, 8, 1, 1, 1);
    add(0, 1, 1, 4, 6, 8, 1, 0, 1);
    // Threshold change alone re-evaluates the alarm.
    add(0, 0, 0, 7, 6, 8, 1, 1, 0);
    add(0, 0, 0, 4, 6, 8, 1, 0, 0);
    // Clear, then misses in FILL never raise the alarm.
    add(1, 0, 0, 4, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4, 0, 1, 0, 0, 1);
    add(0, 1, 0, 4, 0, 2, 0, 0, 1);
    add(0, 1, 0, 4, 0, 3, 0, 0, 1);

    // Reset state.
    step(1, 0, 0, 0, 4);
    check_outs("reset", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(0, tbl[i].clr, tbl[i].valid, tbl[i].hit, tbl[i].thr);
      check_outs($sformatf("vec%0d", i), tbl[i].count, tbl[i].samples,
                 tbl[i].full, tbl[i].low, tbl[i].upd);
    end

    // Clear colliding with a hit at count 5: sample dropped, no pulse.
    step(0, 1, 0, 0, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 4);
    check_outs("pre_clear", 5, 5, 0, 0, 1);
    step(0, 1, 1, 1, 4);
    check_outs("clear_hit", 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 4);
    check_outs("after_clear", 1, 1, 0, 0, 1);

    // Reset mid-fill (with a colliding sample) discards the partial window.
    step(0, 1, 0, 0, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 1, i[0], 4);
    step(1, 0, 1, 1, 4);
    check_outs("reset_mid", 0, 0, 0, 0, 0);
    for (int i = 0; i < W; i++) step(0, 0, 1, 1, 4);
    check_outs("refill", 8, 8, 1, 0, 1);
    step(0, 0, 1, 1, 4);
    check_outs("full_hit", 8, 8, 1, 0, 1);

    // Random traffic against the model; hit bias sweeps to exercise the alarm.
    step(1, 0, 0, 0, 4);
    begin
      logic [CW-1:0] t = 4;
      for (int i = 0; i < 3000; i++) begin
        int bias;
        logic r, c, v, h;
        bias = ((i / 250) % 3 == 0) ? 90 : (((i / 250) % 3 == 1) ? 50 : 15);
        if ($urandom_range(0, 39) == 0) t = CW'($urandom_range(0, 15));
        r = ($urandom_range(0, 499) == 0);
        c = ($urandom_range(0, 79) == 0);
        v = ($urandom_range(0, 9) < 7);
        h = ($urandom_range(0, 99) < bias);
        step(r, c, v, h, t);
        check_outs($sformatf("rnd%0d", i), m_count(), m_q.size(),
                   (m_q.size() == W), m_low, m_upd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
